// File: rtl/char_buffer_pkg.sv
// Shared types and constants for the text-mode character cell store.
// A cell packs {front colour, back colour, character code} into one 32-bit word.
package char_buffer_pkg;

  localparam int CB_H_BITS = 7;
  localparam int CB_V_BITS = 5;
  localparam int CB_COLS   = 2 ** CB_H_BITS;
  localparam int CB_ROWS   = 2 ** CB_V_BITS;

  localparam logic [31:0] CB_CLEAR_WORD = 32'hFFF0_0020;

  // CPU byte address fields: bits [1:0] select a byte within the cell and are ignored
  localparam int COL_LSB = 2;
  localparam int COL_MSB = 8;
  localparam int ROW_LSB = 9;
  localparam int ROW_MSB = 13;

  typedef struct packed {
    logic [11:0] front;
    logic [11:0] back;
    logic [7:0]  chr;
  } cell_t;

  typedef enum logic {
    IDLE,
    CLEARING
  } clr_state_e;

endpackage

// File: rtl/char_buffer_ram.sv
// Simple dual-port cell memory: one write port, one registered read port.
// Read data appears one cycle after the address is sampled; same-address collisions are resolved by the caller.
module char_buffer_ram #(
  parameter int ADDR_BITS = 12,
  parameter int DATA_BITS = 32
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [DATA_BITS-1:0] rdata_o
);

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];
  logic [DATA_BITS-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/char_buffer.sv
// Character cell store between CPU bus and text renderer, with scroll offset, cursor and post-reset clear.
// Cell and cursor outputs have 1-cycle latency; CPU writes arriving while the clear sweep runs are dropped.
module char_buffer
  import char_buffer_pkg::*;
#(
  parameter int          H_BITS     = CB_H_BITS,
  parameter int          V_BITS     = CB_V_BITS,
  parameter logic [31:0] CLEAR_WORD = CB_CLEAR_WORD
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [H_BITS+V_BITS+1:0] wr_addr,
  input  logic [31:0]              wr_data,
  input  logic                     off_we,
  input  logic [V_BITS-1:0]        off_data,
  input  logic                     cur_we,
  input  logic [H_BITS+V_BITS-1:0] cur_data,
  input  logic [H_BITS-1:0]        rd_h,
  input  logic [V_BITS-1:0]        rd_v,
  input  logic                     blink,
  output logic [11:0]              front_color,
  output logic [11:0]              back_color,
  output logic [7:0]               char_code,
  output logic                     cursor,
  output logic [V_BITS-1:0]        line_offset,
  output logic [H_BITS+V_BITS-1:0] cursor_pos,
  output logic                     busy
);

  localparam int IDX_BITS = H_BITS + V_BITS;
  localparam int WR_ROW_LSB = COL_LSB + H_BITS;

  clr_state_e            state_q, state_d;
  logic [IDX_BITS-1:0]   clr_cnt_q, clr_cnt_d;
  logic [V_BITS-1:0]     line_offset_q;
  logic [IDX_BITS-1:0]   cursor_pos_q;
  logic                  cursor_q;
  logic                  rd_clear_q;
  logic                  byp_q;
  logic [31:0]           byp_dat_q;

  logic                  clearing;
  logic                  cpu_wr;
  logic [IDX_BITS-1:0]   wr_idx;
  logic [V_BITS-1:0]     rd_row;
  logic [IDX_BITS-1:0]   rd_idx;
  logic                  ram_we;
  logic [IDX_BITS-1:0]   ram_waddr;
  logic [31:0]           ram_wdata;
  logic [31:0]           ram_rdata;
  logic                  cursor_hit;
  cell_t                 cell_out;
  logic                  wr_addr_unused;

  assign wr_addr_unused = ^wr_addr[COL_LSB-1:0];

  assign clearing = (state_q == CLEARING);
  assign cpu_wr   = wr_en && !clearing;

  // Column-major cell index: {column, row}
  assign wr_idx = {wr_addr[COL_LSB +: H_BITS], wr_addr[WR_ROW_LSB +: V_BITS]};
  assign rd_row = rd_v + line_offset_q;
  assign rd_idx = {rd_h, rd_row};

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEARING: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= CLEARING;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    ram_we    = cpu_wr;
    ram_waddr = wr_idx;
    ram_wdata = wr_data;
    if (clearing) begin
      ram_we    = 1'b1;
      ram_waddr = clr_cnt_q;
      ram_wdata = CLEAR_WORD;
    end
  end

  char_buffer_ram #(
    .ADDR_BITS (IDX_BITS),
    .DATA_BITS (32)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (rd_idx),
    .rdata_o (ram_rdata)
  );

  // Cursor compares against the unscrolled screen row
  assign cursor_hit = blink
                   && (rd_h == cursor_pos_q[H_BITS-1:0])
                   && (rd_v == cursor_pos_q[IDX_BITS-1:H_BITS]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      line_offset_q <= '0;
      cursor_pos_q  <= '0;
      cursor_q      <= 1'b0;
      rd_clear_q    <= 1'b1;
      byp_q         <= 1'b0;
      byp_dat_q     <= CLEAR_WORD;
    end else begin
      if (off_we) begin
        line_offset_q <= off_data;
      end
      if (cur_we) begin
        cursor_pos_q <= cur_data;
      end
      cursor_q   <= cursor_hit;
      rd_clear_q <= clearing;
      byp_q      <= cpu_wr && (wr_idx == rd_idx);
      byp_dat_q  <= wr_data;
    end
  end

  // Write-first: a same-cycle write to the read index overrides the stale RAM word
  always_comb begin
    cell_out = ram_rdata;
    if (rd_clear_q) begin
      cell_out = CLEAR_WORD;
    end else if (byp_q) begin
      cell_out = byp_dat_q;
    end
  end

  assign front_color = cell_out.front;
  assign back_color  = cell_out.back;
  assign char_code   = cell_out.chr;
  assign cursor      = cursor_q;
  assign line_offset = line_offset_q;
  assign cursor_pos  = cursor_pos_q;
  assign busy        = clearing;

endmodule

// File: tb/tb_char_buffer.sv
// Bench for char_buffer: clear sweep, directed vector table, randomized run against a cell-array model.
module tb_char_buffer;
  import char_buffer_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [13:0] wr_addr;
  logic [31:0] wr_data;
  logic        off_we;
  logic [4:0]  off_data;
  logic        cur_we;
  logic [11:0] cur_data;
  logic [6:0]  rd_h;
  logic [4:0]  rd_v;
  logic        blink;
  logic [11:0] front_color;
  logic [11:0] back_color;
  logic [7:0]  char_code;
  logic        cursor;
  logic [4:0]  line_offset;
  logic [11:0] cursor_pos;
  logic        busy;

  char_buffer dut (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .off_we      (off_we),
    .off_data    (off_data),
    .cur_we      (cur_we),
    .cur_data    (cur_data),
    .rd_h        (rd_h),
    .rd_v        (rd_v),
    .blink       (blink),
    .front_color (front_color),
    .back_color  (back_color),
    .char_code   (char_code),
    .cursor      (cursor),
    .line_offset (line_offset),
    .cursor_pos  (cursor_pos),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [13:0] addr;
    logic [31:0] wd;
    logic        ow;
    logic [4:0]  od;
    logic        cw;
    logic [11:0] cd;
    logic [6:0]  h;
    logic [4:0]  v;
    logic        b;
    logic [31:0] exp_cell;
    logic        exp_cur;
    logic [4:0]  exp_off;
    logic [11:0] exp_cpos;
  } vec_t;

  localparam logic [31:0] CLR = 32'hFFF0_0020;

  int          total = 0;
  int          bad = 0;
  logic [31:0] mem_m [4096];
  logic [4:0]  off_m;
  logic [11:0] cur_m;
  vec_t        tbl [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cell_now();
    return {front_color, back_color, char_code};
  endfunction

  function automatic vec_t mk(int we, int addr, logic [31:0] wd, int ow, int od, int cw, int cd,
                              int h, int v, int b, logic [31:0] ecell, int ecur, int eoff, int ecpos);
    vec_t t;
    t.we = 1'(we);  t.addr = 14'(addr); t.wd = wd;
    t.ow = 1'(ow);  t.od = 5'(od);      t.cw = 1'(cw); t.cd = 12'(cd);
    t.h = 7'(h);    t.v = 5'(v);        t.b = 1'(b);
    t.exp_cell = ecell; t.exp_cur = 1'(ecur); t.exp_off = 5'(eoff); t.exp_cpos = 12'(ecpos);
    return t;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    off_we = 1'b0; off_data = '0;
    cur_we = 1'b0; cur_data = '0;
    rd_h = '0; rd_v = '0; blink = 1'b0;
  endtask

  task automatic model_reset();
    foreach (mem_m[i]) mem_m[i] = CLR;
    off_m = '0;
    cur_m = '0;
  endtask

  // Model: a 128x32 cell array; screen row v maps to physical row (v + offset) mod 32
  task automatic run_cycle(input vec_t t, output logic [31:0] e_cell, output logic e_cur);
    int col, row, rrow;
    wr_en = t.we; wr_addr = t.addr; wr_data = t.wd;
    off_we = t.ow; off_data = t.od; cur_we = t.cw; cur_data = t.cd;
    rd_h = t.h; rd_v = t.v; blink = t.b;
    if (t.we) begin
      col = int'(t.addr) / 4 % 128;
      row = int'(t.addr) / 512;
      mem_m[col * 32 + row] = t.wd;
    end
    rrow = (int'(t.v) + int'(off_m)) % 32;
    e_cell = mem_m[int'(t.h) * 32 + rrow];
    e_cur = t.b && (int'(t.h) == int'(cur_m) % 128) && (int'(t.v) == int'(cur_m) / 128);
    if (t.ow) off_m = t.od;
    if (t.cw) cur_m = t.cd;
    tick();
    idle_inputs();
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (busy === 1'b1 && n < 5000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int          n;
    logic [31:0] mc;
    logic        mcur;
    vec_t        r;
    logic [6:0]  rc;
    logic [4:0]  rr;
    logic [1:0]  rb;

    tbl[0]  = mk(1, 'h0A08, 32'h0F000F41, 0, 0, 0, 0,      2, 6,  0, CLR,          0, 0, 'h081);
    tbl[1]  = mk(0, 0,      0,            0, 0, 0, 0,      2, 5,  0, 32'h0F000F41, 0, 0, 'h081);
    tbl[2]  = mk(0, 0,      0,            0, 0, 0, 0,      2, 6,  0, CLR,          0, 0, 'h081);
    tbl[3]  = mk(0, 0,      0,            1, 3, 0, 0,      2, 5,  0, 32'h0F000F41, 0, 3, 'h081);
    tbl[4]  = mk(0, 0,      0,            0, 0, 0, 0,      2, 2,  0, 32'h0F000F41, 0, 3, 'h081);
    tbl[5]  = mk(0, 0,      0,            1, 5, 0, 0,      2, 30, 0, CLR,          0, 5, 'h081);
    tbl[6]  = mk(1, 'h0608, 32'h12345678, 0, 0, 0, 0,      2, 30, 0, 32'h12345678, 0, 5, 'h081);
    tbl[7]  = mk(0, 0,      0,            0, 0, 0, 0,      2, 30, 0, 32'h12345678, 0, 5, 'h081);
    tbl[8]  = mk(0, 0,      0,            1, 0, 0, 0,      2, 30, 0, 32'h12345678, 0, 0, 'h081);
    tbl[9]  = mk(0, 0,      0,            0, 0, 0, 0,      2, 3,  0, 32'h12345678, 0, 0, 'h081);
    tbl[10] = mk(0, 0,      0,            0, 0, 1, 'h20A,  10, 4, 1, CLR,          0, 0, 'h20A);
    tbl[11] = mk(0, 0,      0,            0, 0, 0, 0,      10, 4, 1, CLR,          1, 0, 'h20A);
    tbl[12] = mk(0, 0,      0,            0, 0, 0, 0,      10, 4, 0, CLR,          0, 0, 'h20A);
    tbl[13] = mk(0, 0,      0,            0, 0, 0, 0,      11, 4, 1, CLR,          0, 0, 'h20A);
    tbl[14] = mk(1, 'h0E1C, 32'h11111111, 1, 0, 1, 'h387,  10, 4, 1, CLR,          1, 0, 'h387);
    tbl[15] = mk(1, 'h0E1C, 32'hA5A55A5A, 0, 0, 0, 0,      7, 7,  1, 32'hA5A55A5A, 1, 0, 'h387);
    tbl[16] = mk(0, 0,      0,            0, 0, 0, 0,      7, 7,  1, 32'hA5A55A5A, 1, 0, 'h387);

    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_offset", 32'(line_offset), 32'd0);
    check("rst_cursor_pos", 32'(cursor_pos), 32'd0);
    check("rst_cursor", 32'(cursor), 32'd0);
    check("rst_cell", cell_now(), CLR);

    // First sweep: register writes still land, CPU cell write at cycle 100 is dropped
    reset = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 5000) begin
      idle_inputs();
      if (n == 50) begin cur_we = 1'b1; cur_data = 12'h081; end
      if (n == 60) begin off_we = 1'b1; off_data = 5'd9; end
      if (n == 61) begin off_we = 1'b1; off_data = 5'd0; end
      if (n == 100) begin wr_en = 1'b1; wr_addr = 14'h0204; wr_data = 32'hDEADBEEF; end
      if (n == 200) begin rd_h = 7'd5; rd_v = 5'd7; end
      tick();
      n++;
      if (n == 51) check("cursor_pos_busy", 32'(cursor_pos), 32'h081);
      if (n == 61) check("offset_busy", 32'(line_offset), 32'd9);
      if (n == 201) check("read_busy", cell_now(), CLR);
    end
    idle_inputs();
    check("clear_cycles", 32'(n), 32'd4096);

    model_reset();
    cur_m = 12'h081;
    run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 5, 7, 0, 0, 0, 0, 0), mc, mcur);
    check("cleared_5_7", cell_now(), CLR);
    run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0), mc, mcur);
    check("dropped_write_1_1", cell_now(), CLR);

    for (int i = 0; i < 17; i++) begin
      run_cycle(tbl[i], mc, mcur);
      check($sformatf("vec%0d_cell", i), cell_now(), tbl[i].exp_cell);
      check($sformatf("vec%0d_cursor", i), 32'(cursor), 32'(tbl[i].exp_cur));
      check($sformatf("vec%0d_offset", i), 32'(line_offset), 32'(tbl[i].exp_off));
      check($sformatf("vec%0d_cpos", i), 32'(cursor_pos), 32'(tbl[i].exp_cpos));
    end

    // Narrow column/row windows so writes collide with reads and the cursor gets hit
    for (int i = 0; i < 400; i++) begin
      rc = 7'($urandom_range(0, 3));
      rr = 5'($urandom);
      rb = 2'($urandom);
      r = mk(int'($urandom_range(0, 1)), int'({rr, rc, rb}), $urandom,
             int'($urandom_range(0, 7) == 0), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 7) == 0), int'({5'($urandom_range(0, 3)), 7'($urandom_range(0, 3))}),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
             0, 0, 0, 0);
      run_cycle(r, mc, mcur);
      check($sformatf("rand%0d_cell", i), cell_now(), mc);
      check($sformatf("rand%0d_cursor", i), 32'(cursor), 32'(mcur));
      check($sformatf("rand%0d_regs", i), 32'({line_offset, cursor_pos}), 32'({off_m, cur_m}));
    end

    // Reset again, then interrupt the sweep at cycle 2000
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 2000; i++) begin
      if (i == 10) begin
        off_we = 1'b1; off_data = 5'd9; cur_we = 1'b1; cur_data = 12'h123;
      end
      tick();
      idle_inputs();
    end
    check("busy_mid_sweep", 32'(busy), 32'd1);
    check("offset_mid_sweep", 32'(line_offset), 32'd9);
    reset = 1'b1;
    #2;
    check("midrst_busy", 32'(busy), 32'd1);
    check("midrst_offset", 32'(line_offset), 32'd0);
    check("midrst_cpos", 32'(cursor_pos), 32'd0);
    check("midrst_cell", cell_now(), CLR);
    tick();
    reset = 1'b0;
    wait_clear(n);
    check("restart_cycles", 32'(n), 32'd4096);
    run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 7, 7, 0, 0, 0, 0, 0), mc, mcur);
    check("recleared_7_7", cell_now(), CLR);
    run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 2, 5, 0, 0, 0, 0, 0), mc, mcur);
    check("recleared_2_5", cell_now(), CLR);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/char_buffer.md
Name: char_buffer

Overview:
- Text-mode character cell store between the CPU data bus and the VGA text renderer.
- Holds one 32-bit cell per screen position (128 columns x 32 rows): {front_color[11:0], back_color[11:0], char_code[7:0]}.
- The CPU writes cells by byte address. The renderer reads them by column/row, with hardware vertical scrolling (line offset) and a blinking cursor compare.
- Owns the line-offset and cursor-position registers, and clears the screen after reset.

Parameters:
- H_BITS, 7, column index width (COLS = 2**H_BITS = 128)
- V_BITS, 5, row index width (ROWS = 2**V_BITS = 32)
- CLEAR_WORD, 32'hFFF0_0020, cell value written by the post-reset clear (white on black, space)

Ports:
- clock  in  1  single system clock; all state updates on posedge
- reset  in  1  asynchronous, active-high
- wr_en  in  1  CPU cell write strobe
- wr_addr  in  14  CPU byte address; column = wr_addr[8:2], row = wr_addr[13:9], wr_addr[1:0] ignored
- wr_data  in  32  cell data {front, back, char}
- off_we  in  1  line-offset register write strobe
- off_data  in  5  new line offset
- cur_we  in  1  cursor register write strobe
- cur_data  in  12  new cursor {v[4:0], h[6:0]}
- rd_h  in  7  renderer column
- rd_v  in  5  renderer screen row (before scroll)
- blink  in  1  cursor blink phase (1 = visible)
- front_color  out  12  cell foreground, 1-cycle latency
- back_color  out  12  cell background, 1-cycle latency
- char_code  out  8  cell character, 1-cycle latency
- cursor  out  1  cursor hit, aligned with cell data
- line_offset  out  5  current offset register
- cursor_pos  out  12  current {v, h} cursor register
- busy  out  1  clear sweep in progress

Behaviour:
- Reset (async, active-high):
  - line_offset = 0, cursor_pos = 0, cursor = 0.
  - Read outputs = CLEAR_WORD fields.
  - Clear counter = 0, busy = 1.
- Clear sweep (after reset deasserts):
  - Writes CLEAR_WORD to cell index 0..4095, one per cycle.
  - busy drops in the cycle after index 4095 is written, i.e. 4096 cycles after reset release.
  - While busy: wr_en is ignored (dropped, not queued) and read outputs return CLEAR_WORD.
  - off_we and cur_we still take effect while busy.
  - Reset asserted mid-sweep restarts the sweep from 0.
- Cell index: {column[6:0], row[4:0]} (column-major, 12 bits); write index = {wr_addr[8:2], wr_addr[13:9]}.
- Write: on posedge with wr_en=1 and busy=0, mem[index] <= wr_data.
- Read:
  - Physical row = (rd_v + line_offset) mod 32; 5-bit wrap, e.g. rd_v=30, offset=5 gives row 3.
  - Index {rd_h, physical row} is sampled at posedge; data appears on outputs after that edge (1-cycle latency).
- Read-during-write to the same index in the same cycle is write-first: outputs show wr_data.
- Offset change takes effect on the next read address sampled after the write edge.
- off_we / cur_we: the register updates at posedge; the register outputs reflect the new value after that edge.
- cursor: registered ((rd_h == cursor_h) && (rd_v == cursor_v) && blink), compared against the unscrolled rd_v. Same latency as cell data.
- Simultaneous wr_en, off_we and cur_we are independent; all take effect.
- Memory is inferable as a simple dual-port block RAM: one write port, one registered read port. The bypass mux implements write-first.

Decomposition:
- Shared package (char_buffer_pkg):
  - cell struct typedef {front, back, char}
  - COLS and ROWS constants
  - CLEAR_WORD default
  - address-field slice constants (column bits 8:2, row bits 13:9)
- One sub-module, char_buffer_ram: 4096x32 simple dual-port RAM with registered read.
- Scroll adder, clear FSM (states IDLE/CLEARING), bypass and cursor compare stay in the top module.

Test Plan:
- Reset then wait: busy=1 for 4096 cycles, then 0. Read of any cell (e.g. h=5, v=7) returns front=FFF, back=000, char=20.
- After clear, write wr_addr=14'h0A08 (column 2, row 5) with 32'h0F0_00F_41. Read rd_h=2, rd_v=5 gives char 41, front 0F0, back 00F one cycle later; neighbouring cell (2,6) is unchanged.
- Scroll: off_we with 3, then read rd_h=2, rd_v=2 returns the (2,5) cell. Offset 5 with rd_v=30 reads physical row 3 (wrap).
- Cursor: cur_we with {5'd4, 7'd10}. rd_h=10, rd_v=4, blink=1 gives cursor=1 next cycle; blink=0 or rd_h=11 gives 0.
- Write during busy (cycle 100 after reset) to cell (1,1) is dropped: after clear, (1,1) reads CLEAR_WORD.
- Same-cycle write and read of cell (7,7) outputs the written word. Reset asserted mid-sweep at cycle 2000: busy stays 1 and the sweep restarts, ending 4096 cycles after release.
